// File: rtl/prism_cfg_pkg.sv
// prism_cfg_pkg
//   Shared definitions for the PRISM config sequencer: FSM state encoding,
//   downstream loader register addresses, interface widths and the helper
//   that sizes the post-load drain wait.
package prism_cfg_pkg;

  // Loader-side interface widths.
  localparam int unsigned LdDataW  = 32;
  localparam int unsigned LdAddrW  = 6;
  localparam int unsigned RomAddrW = 4;

  // Loader register map: the MSB half goes through the latch register,
  // writing the LSB half through the debug register kicks off the load.
  localparam logic [LdAddrW-1:0] LdAddrLsb = 6'h10;
  localparam logic [LdAddrW-1:0] LdAddrMsb = 6'h14;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRomRd    = 3'd1,
    StRomCap   = 3'd2,
    StMsbSetup = 3'd3,
    StMsbWr    = 3'd4,
    StLsbWr    = 3'd5,
    StDrain    = 3'd6
  } state_e;

  // Counter value loaded on entry to the drain wait. The loader walks its
  // latch array twice per load, so the wait scales with the array depth.
  // The drain state runs from this value down to and including 0.
  function automatic int unsigned drain_len(input int unsigned depth);
    return 2 * depth;
  endfunction

endpackage

// File: rtl/prism_cfg_sequencer.sv
// prism_cfg_sequencer
//   Feeds 64-bit configuration words into a downstream latch-array config
//   loader. Words come either from a host handshake or, on a boot request,
//   from BOOT_WORDS consecutive entries of a boot ROM. Each word is written
//   as two 32-bit halves: MSB into the latch register (0x14) with
//   ld_latch_wr, then LSB into the debug register (0x10) with ld_debug_wr,
//   which starts the load. The sequencer then waits for the loader to drain
//   before accepting the next word.
//
// Parameters
//   DEPTH       latch-array depth of the loader (sets the drain wait)
//   WIDTH       config word width, only 64 is supported
//   BOOT_WORDS  ROM words per boot sequence, 1..16
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   host_valid   host has a word pending
//   host_data    host word
//   host_ready   host word accepted this cycle
//   boot_start   single-cycle boot request (honoured only when idle)
//   rom_rd       ROM read strobe
//   rom_addr     ROM word index
//   rom_data     ROM word, valid the cycle after rom_rd
//   ld_data      loader data
//   ld_address   loader register address
//   ld_latch_wr  MSB latch write strobe
//   ld_debug_wr  LSB write / load-start strobe
//   busy         high whenever not idle
//   boot_done    one-cycle pulse as the last boot word finishes draining
module prism_cfg_sequencer
  import prism_cfg_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned BOOT_WORDS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_valid,
  input  logic [WIDTH-1:0]    host_data,
  output logic                host_ready,
  input  logic                boot_start,
  output logic                rom_rd,
  output logic [RomAddrW-1:0] rom_addr,
  input  logic [WIDTH-1:0]    rom_data,
  output logic [LdDataW-1:0]  ld_data,
  output logic [LdAddrW-1:0]  ld_address,
  output logic                ld_latch_wr,
  output logic                ld_debug_wr,
  output logic                busy,
  output logic                boot_done
);

  localparam int unsigned CntW = $clog2(drain_len(DEPTH) + 1);
  localparam logic [CntW-1:0]     DrainInit = CntW'(drain_len(DEPTH));
  localparam logic [RomAddrW-1:0] LastIdx   = RomAddrW'(BOOT_WORDS - 1);

  state_e              state_q;
  logic [RomAddrW-1:0] index_q;
  logic [CntW-1:0]     cnt_q;
  logic [WIDTH-1:0]    word_q;
  logic                boot_q;

  logic drain_exit;
  logic boot_last;

  assign drain_exit = (state_q == StDrain) && (cnt_q == '0);
  assign boot_last  = boot_q && (index_q == LastIdx);

  // Sequencer FSM with its datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      boot_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Boot wins over a pending host word; the host simply waits.
          if (boot_start) begin
            index_q <= '0;
            boot_q  <= 1'b1;
            state_q <= StRomRd;
          end else if (host_valid) begin
            word_q  <= host_data;
            boot_q  <= 1'b0;
            state_q <= StMsbSetup;
          end
        end
        StRomRd: begin
          state_q <= StRomCap;
        end
        StRomCap: begin
          word_q  <= rom_data;
          state_q <= StMsbSetup;
        end
        StMsbSetup: begin
          state_q <= StMsbWr;
        end
        StMsbWr: begin
          state_q <= StLsbWr;
        end
        StLsbWr: begin
          cnt_q   <= DrainInit;
          state_q <= StDrain;
        end
        StDrain: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else if (boot_q && !boot_last) begin
            index_q <= index_q + RomAddrW'(1);
            state_q <= StRomRd;
          end else begin
            boot_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode from registered state only, apart from the host handshake
  // which must answer in the cycle the word is offered. Everything is held
  // low while rst is asserted so an abort never emits a late strobe.
  always_comb begin
    host_ready  = 1'b0;
    rom_rd      = 1'b0;
    rom_addr    = '0;
    ld_data     = '0;
    ld_address  = '0;
    ld_latch_wr = 1'b0;
    ld_debug_wr = 1'b0;
    busy        = 1'b0;
    boot_done   = 1'b0;

    if (!rst) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          host_ready = host_valid && !boot_start;
        end
        StRomRd: begin
          rom_rd   = 1'b1;
          rom_addr = index_q;
        end
        StMsbSetup: begin
          ld_address = LdAddrMsb;
          ld_data    = word_q[WIDTH-1:WIDTH-LdDataW];
        end
        StMsbWr: begin
          ld_address  = LdAddrMsb;
          ld_data     = word_q[WIDTH-1:WIDTH-LdDataW];
          ld_latch_wr = 1'b1;
        end
        StLsbWr: begin
          ld_address  = LdAddrLsb;
          ld_data     = word_q[LdDataW-1:0];
          ld_debug_wr = 1'b1;
        end
        StDrain: begin
          boot_done = drain_exit && boot_last;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
